reg_access_arbiter: RTL and testbench
=====================================

Name: reg_access_arbiter

Overview:
- Shares the single-port 128x8 configuration register file between two requesters.
- Requester 0 is the SPI host: it is fed by the SPI address/data decoder after synchronisation into the core clock domain.
- Requester 1 is the on-chip sequencer, used for calibration and readout control.
- Arbitrates per access, drives the register-file port and returns read data and status. It also enforces SPI write protection on the read-only upper address range.

Parameters:
ADDR_W, 7, register-file address width
DATA_W, 8, register-file data width
RO_BASE, 7'h60, first SPI read-only address; SPI writes to addr >= RO_BASE are rejected
MAX_BURST, 4, max consecutive grants to one requester while the other is pending

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
spi_req  in  1  SPI access request, level, held until spi_ack
spi_we  in  1  1 = write, 0 = read; stable while spi_req
spi_addr  in  ADDR_W  SPI target address
spi_wdata  in  DATA_W  SPI write data
spi_ack  out  1  one-cycle completion pulse
spi_rdata  out  DATA_W  read data, valid on spi_ack cycle, held until next ack
spi_err  out  1  valid with spi_ack: write to protected address was dropped
seq_req  in  1  sequencer request, same rules as spi_req
seq_we  in  1  sequencer write enable
seq_addr  in  ADDR_W  sequencer address
seq_wdata  in  DATA_W  sequencer write data
seq_ack  out  1  one-cycle completion pulse
seq_rdata  out  DATA_W  read data, valid on seq_ack cycle
rf_en  out  1  register-file access strobe
rf_we  out  1  register-file write enable, qualified by rf_en
rf_addr  out  ADDR_W  register-file address
rf_wdata  out  DATA_W  register-file write data
rf_rdata  in  DATA_W  register-file read data, 1 cycle after rf_en
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - All outputs 0.
  - State IDLE; last_grant = SEQ, so SPI wins the first tie; burst_cnt = 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
  - IDLE: if any req is high, latch the winner's we/addr/wdata into the command register. Record grant_id, go to ACCESS.
  - ACCESS (1 cycle):
    - rf_en = 1, rf_addr/rf_wdata from the command register.
    - rf_we = cmd_we, except 0 when grant is SPI, we = 1 and addr >= RO_BASE (err_pending = 1).
  - RESP (1 cycle):
    - Pulse the granted ack.
    - Capture rf_rdata into that requester's rdata on reads; rdata is unchanged on writes.
    - spi_err = err_pending (SPI only). Return to IDLE.
- Latency: req sampled high in IDLE at cycle N -> rf_en at N+1 -> ack at N+2. Peak throughput is one access per 3 cycles.
- Requester handshake:
  - Requester may deassert req on the cycle after ack, or keep it high to issue a new access. If req is still high in the IDLE cycle after RESP, it is a new request.
  - Deasserting req before ack is illegal; the arbiter completes the latched access regardless.
  - Input changes after latching are ignored.
- Arbitration (evaluated only in IDLE):
  - Only one requester pending -> grant it.
  - Both pending -> grant the opposite of last_grant, except that a requester whose burst_cnt < MAX_BURST keeps the grant only if it was last_grant AND the other was not pending at its previous grant.
  - Net rule: the same requester never receives more than MAX_BURST consecutive grants while the other is continuously pending.
  - burst_cnt increments on a repeat grant to last_grant, resets to 1 on a switch, and saturates at MAX_BURST.
- Address arithmetic: none; addresses pass through unmodified. RO_BASE compare is unsigned; addr 7'h7F is protected.
- Reset mid-operation: any in-flight access is abandoned. No ack is issued, rf_en drops immediately (async), rdata registers clear.

Decomposition:
- Package reg_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ACCESS, ARB_RESP}
  - typedef enum logic grant_id_t {GNT_SPI, GNT_SEQ}
  - Defaults for ADDR_W, DATA_W, RO_BASE.
- Sub-module rr_grant: two-input round-robin with burst limit. Inputs are both reqs, last_grant and burst_cnt; outputs are grant_id and grant_valid. It is combinational plus the last_grant/burst_cnt registers.
- The FSM, command register and response muxing stay in the top module.

Test Plan:
- SPI-only write: spi_req, we=1, addr=7'h05, wdata=8'hA5 -> rf_en/rf_we at N+1 with addr 05, data A5; spi_ack at N+2; spi_err=0; seq_ack stays 0.
- SPI read after write: read addr 7'h05, model returns A5 -> spi_rdata = 8'hA5 on the ack cycle and held afterwards.
- Protected write: SPI write addr 7'h60, data 8'hFF -> rf_en=1, rf_we=0, spi_ack with spi_err=1. A sequencer write to 7'h60 succeeds with rf_we=1.
- Simultaneous requests from reset: both reqs held high for 8 accesses -> first grant SPI, then strict alternation SPI, SEQ, SPI...; no gap longer than 3 cycles between acks.
- Burst limit: seq_req held continuously, spi_req asserted after 2 SEQ grants -> SPI granted within MAX_BURST=4 total consecutive SEQ grants; burst_cnt never exceeds 4.
- Reset mid-access: assert rst during ACCESS -> rf_en falls immediately, no ack, all outputs 0. After release with spi_req still high -> a fresh access completes in 3 cycles.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and default parameters for the register-file access arbiter.
package reg_arb_pkg;

    localparam int ADDR_W_DEF    = 7;
    localparam int DATA_W_DEF    = 8;
    localparam int RO_BASE_DEF   = 'h60;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        GNT_SPI,
        GNT_SEQ
    } grant_id_t;

endpackage

// File: rtl/reg_access_arbiter_rr_grant.sv
// Two-input round-robin grant with a burst limit. The grant decision is
// combinational; last_grant, burst_cnt and the "other was pending" flag
// update only when the top actually takes a grant.
module rr_grant
    import reg_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      spi_req,
    input  logic      seq_req,
    input  logic      take,
    output grant_id_t grant_id,
    output logic      grant_valid
);

    localparam int CW = $clog2(MAX_BURST + 1);

    grant_id_t      last_grant;
    logic [CW-1:0]  burst_cnt;
    logic           other_pend;
    logic           keep;

    // Tie-break: stay with last_grant only if it has burst budget left and
    // nobody else was waiting when it last won; burst_cnt==0 means no grant
    // yet, so the reset tie goes to the opposite of last_grant (SPI).
    always_comb begin
        keep        = (burst_cnt != '0) && (burst_cnt < CW'(MAX_BURST)) && !other_pend;
        grant_valid = spi_req | seq_req;
        if (spi_req && seq_req)
            grant_id = keep ? last_grant
                            : ((last_grant == GNT_SPI) ? GNT_SEQ : GNT_SPI);
        else if (seq_req)
            grant_id = GNT_SEQ;
        else
            grant_id = GNT_SPI;
    end

    // History registers for the next arbitration round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_SEQ;
            burst_cnt  <= '0;
            other_pend <= 1'b0;
        end else if (take) begin
            last_grant <= grant_id;
            other_pend <= (grant_id == GNT_SPI) ? seq_req : spi_req;
            if (grant_id == last_grant)
                burst_cnt <= (burst_cnt == CW'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
            else
                burst_cnt <= CW'(1);
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares the single-port config register file between the SPI host and the
// on-chip sequencer. One access per IDLE -> ACCESS -> RESP round; SPI writes
// to the upper read-only range are dropped and flagged on spi_err.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RO_BASE   = ADDR_W'(RO_BASE_DEF),
    parameter int                MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_req,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_ack,
    output logic [DATA_W-1:0] spi_rdata,
    output logic              spi_err,
    input  logic              seq_req,
    input  logic              seq_we,
    input  logic [ADDR_W-1:0] seq_addr,
    input  logic [DATA_W-1:0] seq_wdata,
    output logic              seq_ack,
    output logic [DATA_W-1:0] seq_rdata,
    output logic              rf_en,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              busy
);

    arb_state_t        state;
    grant_id_t         gnt;
    grant_id_t         cur_gnt;
    logic              gnt_valid;
    logic              take;
    logic              cmd_we;
    logic              err_pending;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              protect;
    logic [DATA_W-1:0] spi_rdata_q;
    logic [DATA_W-1:0] seq_rdata_q;

    assign take = (state == ARB_IDLE) && gnt_valid;

    rr_grant #(.MAX_BURST(MAX_BURST)) u_grant (
        .clk         (clk),
        .rst         (rst),
        .spi_req     (spi_req),
        .seq_req     (seq_req),
        .take        (take),
        .grant_id    (gnt),
        .grant_valid (gnt_valid)
    );

    // Winner's command, plus the SPI read-only check done before latching.
    always_comb begin
        sel_we    = (gnt == GNT_SPI) ? spi_we    : seq_we;
        sel_addr  = (gnt == GNT_SPI) ? spi_addr  : seq_addr;
        sel_wdata = (gnt == GNT_SPI) ? spi_wdata : seq_wdata;
        protect   = (gnt == GNT_SPI) && sel_we && (sel_addr >= RO_BASE);
    end

    // rf_rdata only arrives in the RESP cycle, so on a read ack it is passed
    // straight through; the held copy covers every other cycle.
    assign spi_rdata = (spi_ack && !cmd_we) ? rf_rdata : spi_rdata_q;
    assign seq_rdata = (seq_ack && !cmd_we) ? rf_rdata : seq_rdata_q;

    // Access FSM with registered register-file strobes and acks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB_IDLE;
            cur_gnt     <= GNT_SPI;
            cmd_we      <= 1'b0;
            err_pending <= 1'b0;
            rf_en       <= 1'b0;
            rf_we       <= 1'b0;
            rf_addr     <= '0;
            rf_wdata    <= '0;
            spi_ack     <= 1'b0;
            seq_ack     <= 1'b0;
            spi_err     <= 1'b0;
            busy        <= 1'b0;
            spi_rdata_q <= '0;
            seq_rdata_q <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (take) begin
                        state       <= ARB_ACCESS;
                        busy        <= 1'b1;
                        cur_gnt     <= gnt;
                        cmd_we      <= sel_we;
                        err_pending <= protect;
                        rf_en       <= 1'b1;
                        rf_we       <= sel_we && !protect;
                        rf_addr     <= sel_addr;
                        rf_wdata    <= sel_wdata;
                    end
                end
                ARB_ACCESS: begin
                    state   <= ARB_RESP;
                    rf_en   <= 1'b0;
                    rf_we   <= 1'b0;
                    spi_ack <= (cur_gnt == GNT_SPI);
                    seq_ack <= (cur_gnt == GNT_SEQ);
                    spi_err <= err_pending;
                end
                ARB_RESP: begin
                    state   <= ARB_IDLE;
                    busy    <= 1'b0;
                    spi_ack <= 1'b0;
                    seq_ack <= 1'b0;
                    spi_err <= 1'b0;
                    if (!cmd_we) begin
                        if (cur_gnt == GNT_SPI) spi_rdata_q <= rf_rdata;
                        else                    seq_rdata_q <= rf_rdata;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a 128x8 register-file model.
module tb_reg_access_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_req, spi_we, seq_req, seq_we;
    logic [6:0] spi_addr, seq_addr;
    logic [7:0] spi_wdata, seq_wdata;
    logic       spi_ack, spi_err, seq_ack;
    logic [7:0] spi_rdata, seq_rdata;
    logic       rf_en, rf_we, busy;
    logic [6:0] rf_addr;
    logic [7:0] rf_wdata, rf_rdata;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [128];

    always #5 clk = ~clk;

    reg_access_arbiter dut (
        .clk(clk), .rst(rst),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_ack(spi_ack), .spi_rdata(spi_rdata), .spi_err(spi_err),
        .seq_req(seq_req), .seq_we(seq_we), .seq_addr(seq_addr), .seq_wdata(seq_wdata),
        .seq_ack(seq_ack), .seq_rdata(seq_rdata),
        .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .busy(busy)
    );

    // Register file: synchronous write, read data registered one cycle after rf_en.
    always @(posedge clk) begin
        if (rf_en) begin
            if (rf_we) mem[rf_addr] <= rf_wdata;
            rf_rdata <= mem[rf_addr];
        end
    end

    task automatic issue(input bit is_seq, input bit we, input logic [6:0] a, input logic [7:0] d);
        if (is_seq) begin seq_req = 1'b1; seq_we = we; seq_addr = a; seq_wdata = d; end
        else        begin spi_req = 1'b1; spi_we = we; spi_addr = a; spi_wdata = d; end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spi_req = 0; spi_we = 0; spi_addr = 0; spi_wdata = 0;
        seq_req = 0; seq_we = 0; seq_addr = 0; seq_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({spi_ack, spi_err, seq_ack, rf_en, rf_we, busy} !== 6'b0 || spi_rdata !== 8'h00 ||
            seq_rdata !== 8'h00 || rf_addr !== 7'h00 || rf_wdata !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: ctl=%b rf_addr=%h rf_wdata=%h spi_rdata=%h seq_rdata=%h, want all 0",
                     {spi_ack, spi_err, seq_ack, rf_en, rf_we, busy}, rf_addr, rf_wdata, spi_rdata, seq_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_spi_write();
        @(negedge clk); issue(0, 1, 7'h05, 8'hA5);
        @(negedge clk);
        tests++;
        if (rf_en !== 1 || rf_we !== 1 || rf_addr !== 7'h05 || rf_wdata !== 8'hA5 || spi_ack !== 0) begin
            fails++;
            $display("FAIL spi_write_access: en=%b we=%b addr=%h data=%h ack=%b, want 1 1 05 A5 0",
                     rf_en, rf_we, rf_addr, rf_wdata, spi_ack);
        end
        @(negedge clk);
        tests++;
        if (spi_ack !== 1 || spi_err !== 0 || seq_ack !== 0 || rf_en !== 0) begin
            fails++;
            $display("FAIL spi_write_ack: spi_ack=%b err=%b seq_ack=%b rf_en=%b, want 1 0 0 0",
                     spi_ack, spi_err, seq_ack, rf_en);
        end
        spi_req = 0;
        @(negedge clk);
        tests++;
        if (spi_ack !== 0 || busy !== 0) begin
            fails++;
            $display("FAIL spi_write_done: ack=%b busy=%b, want 0 0", spi_ack, busy);
        end
    endtask

    task automatic test_spi_read();
        @(negedge clk); issue(0, 0, 7'h05, 8'h00);
        @(negedge clk);
        tests++;
        if (rf_en !== 1 || rf_we !== 0 || rf_addr !== 7'h05) begin
            fails++;
            $display("FAIL spi_read_access: en=%b we=%b addr=%h, want 1 0 05", rf_en, rf_we, rf_addr);
        end
        @(negedge clk);
        tests++;
        if (spi_ack !== 1 || spi_rdata !== 8'hA5) begin
            fails++;
            $display("FAIL spi_read_ack: ack=%b rdata=%h, want 1 A5", spi_ack, spi_rdata);
        end
        spi_req = 0;
        repeat (2) @(negedge clk);
        tests++;
        if (spi_rdata !== 8'hA5) begin
            fails++;
            $display("FAIL spi_read_hold: rdata=%h, want A5", spi_rdata);
        end
    endtask

    task automatic test_protected();
        logic [6:0] addrs [3];
        logic [7:0] datas [3];
        logic       errs  [3];
        addrs = '{7'h5F, 7'h60, 7'h7F};
        datas = '{8'h11, 8'hFF, 8'h22};
        errs  = '{1'b0,  1'b1,  1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); issue(0, 1, addrs[i], datas[i]);
            @(negedge clk);
            tests++;
            if (rf_en !== 1 || rf_we !== !errs[i] || rf_addr !== addrs[i]) begin
                fails++;
                $display("FAIL prot_access[%h]: en=%b we=%b addr=%h, want 1 %b %h",
                         addrs[i], rf_en, rf_we, rf_addr, !errs[i], addrs[i]);
            end
            @(negedge clk);
            tests++;
            if (spi_ack !== 1 || spi_err !== errs[i]) begin
                fails++;
                $display("FAIL prot_err[%h]: ack=%b err=%b, want 1 %b", addrs[i], spi_ack, spi_err, errs[i]);
            end
            spi_req = 0;
            @(negedge clk);
        end
        // Sequencer is not subject to the read-only range.
        @(negedge clk); issue(1, 1, 7'h60, 8'h5A);
        @(negedge clk);
        tests++;
        if (rf_en !== 1 || rf_we !== 1 || rf_addr !== 7'h60 || rf_wdata !== 8'h5A) begin
            fails++;
            $display("FAIL seq_write_60: en=%b we=%b addr=%h data=%h, want 1 1 60 5A",
                     rf_en, rf_we, rf_addr, rf_wdata);
        end
        @(negedge clk);
        tests++;
        if (seq_ack !== 1 || spi_ack !== 0) begin
            fails++;
            $display("FAIL seq_write_ack: seq_ack=%b spi_ack=%b, want 1 0", seq_ack, spi_ack);
        end
        seq_req = 0;
        @(negedge clk);
        // 0x60 must hold the sequencer value, not the dropped SPI 0xFF.
        @(negedge clk); issue(0, 0, 7'h60, 8'h00);
        repeat (2) @(negedge clk);
        tests++;
        if (spi_ack !== 1 || spi_rdata !== 8'h5A) begin
            fails++;
            $display("FAIL prot_readback: ack=%b rdata=%h, want 1 5A", spi_ack, spi_rdata);
        end
        spi_req = 0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int n = 0;
        int last = 0;
        pulse_reset();
        issue(0, 0, 7'h05, 8'h00);
        issue(1, 0, 7'h60, 8'h00);
        for (int cyc = 1; cyc <= 40 && n < 8; cyc++) begin
            @(negedge clk);
            if (spi_ack || seq_ack) begin
                tests++;
                if (spi_ack === seq_ack || seq_ack !== n[0]) begin
                    fails++;
                    $display("FAIL alt_order[%0d]: spi_ack=%b seq_ack=%b, want seq_ack=%b only",
                             n, spi_ack, seq_ack, n[0]);
                end
                tests++;
                if (cyc - last > 3 || (n == 0 && cyc != 2)) begin
                    fails++;
                    $display("FAIL alt_gap[%0d]: ack at cycle %0d, previous %0d, want gap <= 3 (first at 2)",
                             n, cyc, last);
                end
                tests++;
                if ((spi_ack && spi_rdata !== 8'hA5) || (seq_ack && seq_rdata !== 8'h5A)) begin
                    fails++;
                    $display("FAIL alt_rdata[%0d]: spi=%h seq=%h, want A5 / 5A", n, spi_rdata, seq_rdata);
                end
                last = cyc;
                n++;
            end
        end
        tests++;
        if (n != 8) begin
            fails++;
            $display("FAIL alt_count: %0d acks within budget, want 8", n);
        end
        spi_req = 0; seq_req = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_burst();
        int  run = 0;
        int  max_run = 0;
        int  seq_cnt = 0;
        bit  got_spi = 0;
        bit  done = 0;
        pulse_reset();
        issue(1, 0, 7'h60, 8'h00);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (seq_ack) begin
                seq_cnt++;
                if (!got_spi) begin
                    run++;
                    if (run > max_run) max_run = run;
                end
                if (seq_cnt == 2) issue(0, 0, 7'h05, 8'h00);
                if (got_spi) begin seq_req = 0; done = 1; end
            end
            if (spi_ack) begin
                got_spi = 1;
                spi_req = 0;
            end
        end
        tests++;
        if (!got_spi || !done) begin
            fails++;
            $display("FAIL burst_spi_grant: spi granted=%b seq resumed=%b, want 1 1", got_spi, done);
        end
        tests++;
        if (max_run > 4 || max_run < 2) begin
            fails++;
            $display("FAIL burst_limit: %0d consecutive SEQ grants, want 2..4", max_run);
        end
        spi_req = 0; seq_req = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk); issue(0, 1, 7'h10, 8'h33);
        @(negedge clk);
        tests++;
        if (rf_en !== 1) begin
            fails++;
            $display("FAIL mid_access: rf_en=%b, want 1", rf_en);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({spi_ack, spi_err, seq_ack, rf_en, rf_we, busy} !== 6'b0 || spi_rdata !== 8'h00 ||
            seq_rdata !== 8'h00 || rf_addr !== 7'h00 || rf_wdata !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset_outputs: ctl=%b spi_rdata=%h seq_rdata=%h rf_addr=%h, want all 0",
                     {spi_ack, spi_err, seq_ack, rf_en, rf_we, busy}, spi_rdata, seq_rdata, rf_addr);
        end
        @(negedge clk);
        tests++;
        if (spi_ack !== 0 || rf_en !== 0) begin
            fails++;
            $display("FAIL mid_no_ack: ack=%b rf_en=%b, want 0 0", spi_ack, rf_en);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (rf_en !== 1 || rf_addr !== 7'h10 || rf_wdata !== 8'h33) begin
            fails++;
            $display("FAIL mid_restart_access: en=%b addr=%h data=%h, want 1 10 33", rf_en, rf_addr, rf_wdata);
        end
        @(negedge clk);
        tests++;
        if (spi_ack !== 1 || spi_err !== 0) begin
            fails++;
            $display("FAIL mid_restart_ack: ack=%b err=%b, want 1 0", spi_ack, spi_err);
        end
        spi_req = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_spi_write();
        test_spi_read();
        test_protected();
        test_simultaneous();
        test_burst();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
